// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame sizes, host-transmitter states and the odd-parity helper.
package ps2_pkg;

    localparam int PS2_FRAME_BITS = 11;
    localparam int PS2_TX_BITS    = 10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INHIBIT  = 3'd1,
        ST_REQ      = 3'd2,
        ST_SEND     = 3'd3,
        ST_ACK      = 3'd4,
        ST_WAIT_REL = 3'd5
    } ps2_tx_state_e;

    function automatic logic ps2_odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronisers for the PS/2 clock and data lines, plus a one-cycle falling-edge strobe on the clock.
module ps2_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk_in,
    input  logic ps2_data_in,
    output logic clk_s,
    output logic data_s,
    output logic clk_fall
);

    logic [1:0] clk_meta_q, clk_meta_d;
    logic [1:0] data_meta_q, data_meta_d;
    logic       clk_prev_q, clk_prev_d;

    always_comb begin
        clk_meta_d  = {clk_meta_q[0], ps2_clk_in};
        data_meta_d = {data_meta_q[0], ps2_data_in};
        clk_prev_d  = clk_meta_q[1];
    end

    // Idle bus level is high, so reset to 1 to avoid a spurious fall strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_meta_q  <= '1;
            data_meta_q <= '1;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_meta_q  <= clk_meta_d;
            data_meta_q <= data_meta_d;
            clk_prev_q  <= clk_prev_d;
        end
    end

    assign clk_s    = clk_meta_q[1];
    assign data_s   = data_meta_q[1];
    assign clk_fall = clk_prev_q & ~clk_meta_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter (request-to-send, LSB-first shift, ACK check).
// Define PS2_TX_ACK_CHECK_EN to turn a high ACK sample into a tx_err pulse.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    ps2_tx_state_e          state_q, state_d;
    logic [PS2_TX_BITS-1:0] frame_q, frame_d;
    logic [3:0]             bit_idx_q, bit_idx_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   data_oe_q, data_oe_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
`ifdef PS2_TX_ACK_CHECK_EN
    logic                   ack_q, ack_d;
`endif

    logic clk_s, data_s, clk_fall;

    ps2_line_sync u_sync (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .clk_s      (clk_s),
        .data_s     (data_s),
        .clk_fall   (clk_fall)
    );

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        bit_idx_d = bit_idx_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
`ifdef PS2_TX_ACK_CHECK_EN
        ack_d     = ack_q;
`endif

        case (state_q)
            ST_IDLE: begin
                data_oe_d = 1'b0;
                if (tx_valid) begin
                    frame_d = {1'b1, ps2_odd_parity(tx_data), tx_data};
                    cnt_d   = '0;
                    state_d = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    data_oe_d = 1'b1;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                bit_idx_d = '0;
                cnt_d     = '0;
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                if (clk_fall) begin
                    data_oe_d = ~frame_q[bit_idx_q];
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 4'(PS2_TX_BITS - 1)) begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                if (clk_fall) begin
`ifdef PS2_TX_ACK_CHECK_EN
                    ack_d = data_s;
`endif
                    state_d = ST_WAIT_REL;
                end
            end
            ST_WAIT_REL: begin
                if (clk_s && data_s) begin
                    state_d = ST_IDLE;
`ifdef PS2_TX_ACK_CHECK_EN
                    err_d   = ack_q;
                    done_d  = ~ack_q;
`else
                    done_d  = 1'b1;
`endif
                end
            end
            default: begin
                data_oe_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase

        // Timeout wins over any legal event landing in the same cycle.
        if ((state_q == ST_SEND || state_q == ST_ACK || state_q == ST_WAIT_REL) &&
            cnt_q == TO_LAST) begin
            state_d   = ST_IDLE;
            data_oe_d = 1'b0;
            done_d    = 1'b0;
            err_d     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            frame_q   <= '0;
            bit_idx_q <= '0;
            cnt_q     <= '0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
            ack_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            bit_idx_q <= bit_idx_d;
            cnt_q     <= cnt_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef PS2_TX_ACK_CHECK_EN
            ack_q     <= ack_d;
`endif
        end
    end

    assign tx_ready    = (state_q == ST_IDLE);
    assign tx_busy     = (state_q != ST_IDLE);
    assign tx_done     = done_q;
    assign tx_err      = err_q;
    assign ps2_clk_oe  = (state_q == ST_INHIBIT) || (state_q == ST_REQ);
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: open-drain line model plus a behavioural PS/2 device.
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int TO  = 1000;
    localparam int H   = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, tx_busy, tx_done, tx_err;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_in, ps2_data_in;

    int tests = 0;
    int fails = 0;
    int n_done = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_err     (tx_err),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected line sequence seen by the device: start, d0..d7, odd parity, stop.
    function automatic logic [10:0] exp_frame(input logic [7:0] b);
        int  ones;
        logic par;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        par = (ones % 2 == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, b, 1'b0};
    endfunction

    // Per-cycle invariants and pulse counting.
    always @(negedge clk) begin
        if (!reset) begin
            check("ready_vs_busy", tx_ready, !tx_busy);
            if (!tx_busy) check("idle_lines_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
            check("pulse_exclusive", tx_done & tx_err, 1'b0);
            if (tx_done) n_done++;
            if (tx_err) n_err++;
        end
    end

    task automatic send(input logic [7:0] b);
        int g;
        g = 0;
        while (!tx_ready && g < 5000) begin @(negedge clk); g++; end
        check("ready_before_send", tx_ready, 1'b1);
        tx_valid = 1'b1;
        tx_data  = b;
        @(negedge clk);
        tx_valid = 1'b0;
        check("ready_low_after_accept", tx_ready, 1'b0);
    endtask

    // Behavioural device: measures request-to-send, clocks 11 falls, reads each bit before its fall.
    task automatic dev_xfer(input logic ack, input int abort_at, output logic [10:0] got);
        int g;
        int hi;
        got = '0;
        g = 0;
        hi = 0;
        while (!ps2_clk_oe && g < 100) begin @(negedge clk); g++; end
        while (ps2_clk_oe && hi < INH + 100) begin @(negedge clk); hi++; end
        check("inhibit_len", hi, INH + 1);
        check("start_bit_held", ps2_data_oe, 1'b1);
        for (int i = 0; i < 11; i++) begin
            if (i == abort_at) return;
            repeat (H) @(negedge clk);
            got[i] = ps2_data_in;
            if (i == 10) dev_data = ack;
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            dev_clk = 1'b1;
            if (i == 10) dev_data = 1'b1;
        end
        g = 0;
        while (!(tx_done || tx_err) && g < 200) begin @(negedge clk); g++; end
        check("frame_end_seen", (g < 200), 1'b1);
    endtask

    initial begin
        #2_000_000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] got;
        int d0, e0, n;

        repeat (3) @(negedge clk);
        check("rst_ready", tx_ready, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_pulses", {tx_done, tx_err}, 2'b00);
        check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        reset = 1'b0;
        @(negedge clk);

        // 0xED with good ACK
        d0 = n_done; e0 = n_err;
        send(8'hED);
        dev_xfer(1'b0, -1, got);
        check("frame_ED_model", got, exp_frame(8'hED));
        check("frame_ED_literal", got, 11'b1_1_1110_1101_0);
        repeat (3) @(negedge clk);
        check("ED_done_count", n_done - d0, 1);
        check("ED_err_count", n_err - e0, 0);

        // parity boundaries
        send(8'h00);
        dev_xfer(1'b0, -1, got);
        check("frame_00_model", got, exp_frame(8'h00));
        check("frame_00_literal", got, 11'b1_1_0000_0000_0);
        send(8'hFF);
        dev_xfer(1'b0, -1, got);
        check("frame_FF_model", got, exp_frame(8'hFF));
        check("frame_FF_literal", got, 11'b1_1_1111_1111_0);
        repeat (3) @(negedge clk);

        // device never clocks: timeout
        d0 = n_done; e0 = n_err;
        send(8'h5A);
        n = 0;
        while (ps2_clk_oe && n < INH + 100) begin @(negedge clk); n++; end
        n = 0;
        while (!tx_err && n < TO + 50) begin @(negedge clk); n++; end
        check("timeout_cycles", n, TO);
        check("timeout_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        check("timeout_ready", tx_ready, 1'b1);
        repeat (3) @(negedge clk);
        check("timeout_err_count", n_err - e0, 1);
        check("timeout_done_count", n_done - d0, 0);

        // device NAK (ACK sampled high)
        d0 = n_done; e0 = n_err;
        send(8'hF0);
        dev_xfer(1'b1, -1, got);
        check("frame_F0_model", got, exp_frame(8'hF0));
        repeat (3) @(negedge clk);
`ifdef PS2_TX_ACK_CHECK_EN
        check("nak_done_count", n_done - d0, 0);
        check("nak_err_count", n_err - e0, 1);
`else
        check("nak_done_count", n_done - d0, 1);
        check("nak_err_count", n_err - e0, 0);
`endif

        // reset after 4 data bits
        d0 = n_done; e0 = n_err;
        send(8'h96);
        dev_xfer(1'b0, 5, got);
        check("pre_reset_busy", tx_busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        check("midrst_ready", tx_ready, 1'b1);
        check("midrst_pulses", {tx_done, tx_err}, 2'b00);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_no_pulse_count", (n_done - d0) + (n_err - e0), 0);
        send(8'hF4);
        dev_xfer(1'b0, -1, got);
        check("frame_F4_model", got, exp_frame(8'hF4));
        check("frame_F4_literal", got, 11'b1_0_1111_0100_0);
        repeat (3) @(negedge clk);

        // valid held, data changed mid-frame; back-to-back accept on tx_done
        d0 = n_done; e0 = n_err;
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        @(negedge clk);
        fork
            dev_xfer(1'b0, -1, got);
            begin
                repeat (60) @(negedge clk);
                tx_data = 8'h3C;
            end
        join
        check("frame_A5_model", got, exp_frame(8'hA5));
        check("done_cycle_ready", tx_ready & tx_done, 1'b1);
        @(negedge clk);
        tx_valid = 1'b0;
        check("reaccept_busy", tx_busy, 1'b1);
        dev_xfer(1'b0, -1, got);
        check("frame_3C_model", got, exp_frame(8'h3C));
        repeat (3) @(negedge clk);
        check("b2b_done_count", n_done - d0, 2);
        check("b2b_err_count", n_err - e0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
